exe_stage: RTL and testbench

Execute stage of the pipelined Y86-64 datapath, 32-bit datapath variant. It holds the E pipeline register loaded from decode and selects ALU operands and function (add/sub/and/xor). It owns the condition-code register (ZF/SF/OF) and evaluates the jXX/cmovXX condition. Its outputs feed the M pipeline register.

---
 rtl/exe_if.sv | 53 +++++
 rtl/exe_stage.sv | 256 +++++++++++++++++++++++++
 tb/tb_exe_stage.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/exe_if.sv
// exe_if -- bus between the decode side and the execute stage.
//
// Carries the decoded instruction into the E pipeline register and the
// execute results toward the M pipeline register.
//
//   master : decode/memory side (drives d_*, observes E_*, e_*, cc)
//   slave  : exe_stage (observes d_*, drives E_*, e_*, cc)
//
// Signals:
//   d_stat[2:0]   decode status (1 AOK, 2 HLT, 3 ADR, 4 INS)
//   d_icode/ifun  decoded instruction
//   d_valA/B/C    operands, W bits
//   d_dstE/dstM   destination registers (0xF = none)
//   E_stat        registered status
//   E_icode/ifun  registered instruction
//   E_valA        registered valA (passed to M)
//   E_dstM        registered dstM
//   e_valE        ALU result (combinational)
//   e_dstE        effective dstE (0xF when a cmov is not taken)
//   e_cnd         condition result
//   cc            {ZF,SF,OF} condition-code register
interface exe_if #(
    parameter int W = 32
);
    logic [2:0]   d_stat;
    logic [3:0]   d_icode;
    logic [3:0]   d_ifun;
    logic [W-1:0] d_valA;
    logic [W-1:0] d_valB;
    logic [W-1:0] d_valC;
    logic [3:0]   d_dstE;
    logic [3:0]   d_dstM;

    logic [2:0]   E_stat;
    logic [3:0]   E_icode;
    logic [3:0]   E_ifun;
    logic [W-1:0] E_valA;
    logic [3:0]   E_dstM;
    logic [W-1:0] e_valE;
    logic [3:0]   e_dstE;
    logic         e_cnd;
    logic [2:0]   cc;

    modport master (
        output d_stat, d_icode, d_ifun, d_valA, d_valB, d_valC, d_dstE, d_dstM,
        input  E_stat, E_icode, E_ifun, E_valA, E_dstM, e_valE, e_dstE, e_cnd, cc
    );

    modport slave (
        input  d_stat, d_icode, d_ifun, d_valA, d_valB, d_valC, d_dstE, d_dstM,
        output E_stat, E_icode, E_ifun, E_valA, E_dstM, e_valE, e_dstE, e_cnd, cc
    );
endinterface

// File: rtl/exe_stage.sv
// exe_stage -- execute stage of a pipelined Y86-64 datapath (W-bit variant).
//
// Holds the E pipeline register loaded from decode, selects ALU operands and
// function, owns the {ZF,SF,OF} condition-code register and evaluates the
// jXX / cmovXX condition. Results feed the M pipeline register.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (E <- bubble, cc <- 3'b100)
//   e_stall   hold the E register (and suppress the cc write)
//   e_bubble  load a nop bubble into E (wins over e_stall)
//   m_exc     exception present in the M stage
//   w_exc     exception present in the W stage
//   bus       exe_if.slave: d_* in, E_* / e_* / cc out
//
// Build option:
//   EXE_EXC_CC_GATE_EN  when defined, the cc write also requires no exception
//                       in M or W and an AOK status in E, so an instruction
//                       behind a faulting one cannot alter the flags. When
//                       undefined, m_exc / w_exc are ignored.
//
// No handshake: the stage advances every cycle unless stalled or bubbled.
module exe_stage #(
    parameter int W = 32
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   e_stall,
    input  logic   e_bubble,
    input  logic   m_exc,
    input  logic   w_exc,
    exe_if.slave   bus
);

    // Instruction codes
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;   // also cmovXX
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [2:0] S_AOK    = 3'd1;

    // Stack-pointer adjust constants
    localparam logic [W-1:0] NEG8 = {{(W-4){1'b1}}, 4'b1000};
    localparam logic [W-1:0] POS8 = W'(8);

    // ------------------------------------------------------------------
    // E pipeline register
    // ------------------------------------------------------------------
    logic [2:0]   stat_q,  stat_d;
    logic [3:0]   icode_q, icode_d;
    logic [3:0]   ifun_q,  ifun_d;
    logic [W-1:0] valA_q,  valA_d;
    logic [W-1:0] valB_q,  valB_d;
    logic [W-1:0] valC_q,  valC_d;
    logic [3:0]   dstE_q,  dstE_d;
    logic [3:0]   dstM_q,  dstM_d;

    always_comb begin
        stat_d  = stat_q;
        icode_d = icode_q;
        ifun_d  = ifun_q;
        valA_d  = valA_q;
        valB_d  = valB_q;
        valC_d  = valC_q;
        dstE_d  = dstE_q;
        dstM_d  = dstM_q;
        if (e_bubble) begin
            stat_d  = S_AOK;
            icode_d = I_NOP;
            ifun_d  = 4'h0;
            valA_d  = '0;
            valB_d  = '0;
            valC_d  = '0;
            dstE_d  = R_NONE;
            dstM_d  = R_NONE;
        end else if (!e_stall) begin
            stat_d  = bus.d_stat;
            icode_d = bus.d_icode;
            ifun_d  = bus.d_ifun;
            valA_d  = bus.d_valA;
            valB_d  = bus.d_valB;
            valC_d  = bus.d_valC;
            dstE_d  = bus.d_dstE;
            dstM_d  = bus.d_dstM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q  <= S_AOK;
            icode_q <= I_NOP;
            ifun_q  <= 4'h0;
            valA_q  <= '0;
            valB_q  <= '0;
            valC_q  <= '0;
            dstE_q  <= R_NONE;
            dstM_q  <= R_NONE;
        end else begin
            stat_q  <= stat_d;
            icode_q <= icode_d;
            ifun_q  <= ifun_d;
            valA_q  <= valA_d;
            valB_q  <= valB_d;
            valC_q  <= valC_d;
            dstE_q  <= dstE_d;
            dstM_q  <= dstM_d;
        end
    end

    // ------------------------------------------------------------------
    // ALU operand selection
    // ------------------------------------------------------------------
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;

    always_comb begin
        alu_a = '0;
        case (icode_q)
            I_RRMOVQ, I_OPQ:             alu_a = valA_q;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = valC_q;
            I_CALL, I_PUSHQ:             alu_a = NEG8;
            I_RET, I_POPQ:               alu_a = POS8;
            default:                     alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (icode_q)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
            I_RET, I_PUSHQ, I_POPQ:      alu_b = valB_q;
            default:                     alu_b = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU and flag generation
    // ------------------------------------------------------------------
    logic [W-1:0] sum_w;
    logic [W-1:0] diff_w;
    logic [W-1:0] alu_r;
    logic         alu_of;
    logic         alu_zf;
    logic         alu_sf;

    assign sum_w  = alu_b + alu_a;
    assign diff_w = alu_b - alu_a;

    always_comb begin
        alu_r  = sum_w;
        alu_of = (alu_a[W-1] == alu_b[W-1]) && (sum_w[W-1] != alu_b[W-1]);
        if (icode_q == I_OPQ) begin
            case (ifun_q)
                4'h0: begin
                    alu_r  = sum_w;
                    alu_of = (alu_a[W-1] == alu_b[W-1]) && (sum_w[W-1] != alu_b[W-1]);
                end
                4'h1: begin
                    alu_r  = diff_w;
                    alu_of = (alu_a[W-1] != alu_b[W-1]) && (diff_w[W-1] != alu_b[W-1]);
                end
                4'h2: begin
                    alu_r  = alu_b & alu_a;
                    alu_of = 1'b0;
                end
                4'h3: begin
                    alu_r  = alu_b ^ alu_a;
                    alu_of = 1'b0;
                end
                default: begin
                    // Undefined OPq function: zero result, flags follow from it
                    alu_r  = '0;
                    alu_of = 1'b0;
                end
            endcase
        end
    end

    assign alu_zf = (alu_r == '0);
    assign alu_sf = alu_r[W-1];

    // ------------------------------------------------------------------
    // Condition-code register {ZF,SF,OF}
    // ------------------------------------------------------------------
    logic [2:0] cc_q, cc_d;
    logic       cc_we;

`ifdef EXE_EXC_CC_GATE_EN
    // A faulting instruction further down the pipe freezes the flags.
    assign cc_we = (icode_q == I_OPQ) && !e_stall &&
                   !m_exc && !w_exc && (stat_q == S_AOK);
`else
    logic unused_exc;
    assign unused_exc = m_exc | w_exc;
    assign cc_we = (icode_q == I_OPQ) && !e_stall;
`endif

    assign cc_d = cc_we ? {alu_zf, alu_sf, alu_of} : cc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q <= 3'b100;
        end else begin
            cc_q <= cc_d;
        end
    end

    // ------------------------------------------------------------------
    // Condition evaluation from the current (registered) flags
    // ------------------------------------------------------------------
    logic zf, sf, of;
    logic cond;

    assign {zf, sf, of} = cc_q;

    always_comb begin
        cond = 1'b0;
        case (ifun_q)
            4'h0: cond = 1'b1;
            4'h1: cond = (sf ^ of) | zf;
            4'h2: cond = sf ^ of;
            4'h3: cond = zf;
            4'h4: cond = !zf;
            4'h5: cond = !(sf ^ of);
            4'h6: cond = !(sf ^ of) && !zf;
            default: cond = 1'b0;
        endcase
    end

    logic e_cnd_w;
    assign e_cnd_w = ((icode_q == I_RRMOVQ) || (icode_q == I_JXX)) ? cond : 1'b0;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.E_stat  = stat_q;
    assign bus.E_icode = icode_q;
    assign bus.E_ifun  = ifun_q;
    assign bus.E_valA  = valA_q;
    assign bus.E_dstM  = dstM_q;
    assign bus.e_valE  = alu_r;
    assign bus.e_cnd   = e_cnd_w;
    // A cmov that is not taken must not write its destination.
    assign bus.e_dstE  = ((icode_q == I_RRMOVQ) && !e_cnd_w) ? R_NONE : dstE_q;
    assign bus.cc      = cc_q;

endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage -- directed bench for exe_stage with hand-computed expectations.
module tb_exe_stage;

    localparam int W = 32;

    logic clk;
    logic rst_n;
    logic e_stall;
    logic e_bubble;
    logic m_exc;
    logic w_exc;

    int n_checks;
    int n_errors;

    exe_if #(.W(W)) bus ();

    exe_stage #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .e_stall  (e_stall),
        .e_bubble (e_bubble),
        .m_exc    (m_exc),
        .w_exc    (w_exc),
        .bus      (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [2:0] stat, input logic [3:0] icode,
                         input logic [3:0] ifun, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] vc,
                         input logic [3:0] dste, input logic [3:0] dstm);
        bus.d_stat  = stat;
        bus.d_icode = icode;
        bus.d_ifun  = ifun;
        bus.d_valA  = va;
        bus.d_valB  = vb;
        bus.d_valC  = vc;
        bus.d_dstE  = dste;
        bus.d_dstM  = dstm;
    endtask

    // Advance one clock; return 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b1;
        e_stall  = 1'b0;
        e_bubble = 1'b0;
        m_exc    = 1'b0;
        w_exc    = 1'b0;
        drive(3'd1, 4'h6, 4'h0, 32'd3, 32'd4, 32'd0, 4'h2, 4'hF);
        tick();

        // Asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        check("rst_icode", {28'd0, bus.E_icode}, 32'h1);
        check("rst_stat",  {29'd0, bus.E_stat},  32'h1);
        check("rst_cc",    {29'd0, bus.cc},      32'h4);
        check("rst_dstE",  {28'd0, bus.e_dstE},  32'hF);
        check("rst_dstM",  {28'd0, bus.E_dstM},  32'hF);
        check("rst_valE",  bus.e_valE,           32'h0);
        check("rst_cnd",   {31'd0, bus.e_cnd},   32'h0);
        tick();
        rst_n = 1'b1;
        check("rst_hold_icode", {28'd0, bus.E_icode}, 32'h1);

        // OPq add with signed overflow
        drive(3'd1, 4'h6, 4'h0, 32'h7FFFFFFF, 32'h1, 32'h0, 4'h3, 4'hF);
        tick();
        check("add_icode", {28'd0, bus.E_icode}, 32'h6);
        check("add_valE",  bus.e_valE,           32'h80000000);
        check("add_valA",  bus.E_valA,           32'h7FFFFFFF);
        check("add_dstE",  {28'd0, bus.e_dstE},  32'h3);
        check("add_cnd",   {31'd0, bus.e_cnd},   32'h0);
        check("add_cc_old", {29'd0, bus.cc},     32'h4);

        // OPq sub 5-5; add flags land now
        drive(3'd1, 4'h6, 4'h1, 32'd5, 32'd5, 32'h0, 4'h4, 4'hF);
        tick();
        check("add_cc",   {29'd0, bus.cc}, 32'h3);
        check("sub_valE", bus.e_valE,      32'h0);

        // jle after sub
        drive(3'd1, 4'h7, 4'h1, 32'h0, 32'h0, 32'h40, 4'hF, 4'hF);
        tick();
        check("sub_cc",   {29'd0, bus.cc},     32'h4);
        check("jle_cnd",  {31'd0, bus.e_cnd},  32'h1);
        check("jle_valE", bus.e_valE,          32'h0);

        // cmovg not taken with ZF=1
        drive(3'd1, 4'h2, 4'h6, 32'd9, 32'h0, 32'h0, 4'h3, 4'hF);
        tick();
        check("cmovg_valE", bus.e_valE,          32'd9);
        check("cmovg_cnd",  {31'd0, bus.e_cnd},  32'h0);
        check("cmovg_dstE", {28'd0, bus.e_dstE}, 32'hF);

        // cmovle taken
        drive(3'd1, 4'h2, 4'h1, 32'd9, 32'h0, 32'h0, 4'h3, 4'hF);
        tick();
        check("cmovle_cnd",  {31'd0, bus.e_cnd},  32'h1);
        check("cmovle_dstE", {28'd0, bus.e_dstE}, 32'h3);

        // push / ret stack adjust
        drive(3'd1, 4'hA, 4'h0, 32'h0, 32'h100, 32'h0, 4'h4, 4'hF);
        tick();
        check("push_valE", bus.e_valE, 32'hF8);
        drive(3'd1, 4'h9, 4'h0, 32'h0, 32'h100, 32'h0, 4'h4, 4'hF);
        tick();
        check("ret_valE", bus.e_valE,      32'h108);
        check("ret_cc",   {29'd0, bus.cc}, 32'h4);

        // and / xor / undefined OPq / sub overflow
        drive(3'd1, 4'h6, 4'h2, 32'h0000F0F0, 32'h0000FF00, 32'h0, 4'h1, 4'hF);
        tick();
        check("and_valE", bus.e_valE, 32'h0000F000);
        drive(3'd1, 4'h6, 4'h3, 32'h80000000, 32'h0, 32'h0, 4'h1, 4'hF);
        tick();
        check("and_cc",   {29'd0, bus.cc}, 32'h0);
        check("xor_valE", bus.e_valE,      32'h80000000);
        drive(3'd1, 4'h6, 4'h7, 32'd3, 32'd4, 32'h0, 4'h1, 4'hF);
        tick();
        check("xor_cc",   {29'd0, bus.cc}, 32'h2);
        check("opq7_valE", bus.e_valE,     32'h0);
        drive(3'd1, 4'h6, 4'h1, 32'h1, 32'h80000000, 32'h0, 4'h1, 4'hF);
        tick();
        check("opq7_cc",  {29'd0, bus.cc}, 32'h4);
        check("subov_valE", bus.e_valE,    32'h7FFFFFFF);

        // jl / jge on OF=1
        drive(3'd1, 4'h7, 4'h2, 32'h0, 32'h0, 32'h0, 4'hF, 4'hF);
        tick();
        check("subov_cc", {29'd0, bus.cc},    32'h1);
        check("jl_cnd",   {31'd0, bus.e_cnd}, 32'h1);
        drive(3'd1, 4'h7, 4'h5, 32'h0, 32'h0, 32'h0, 4'hF, 4'hF);
        tick();
        check("jge_cnd",  {31'd0, bus.e_cnd}, 32'h0);

        // rmmovq address
        drive(3'd1, 4'h4, 4'h0, 32'h0, 32'h20, 32'h10, 4'hF, 4'hF);
        tick();
        check("rmmov_valE", bus.e_valE, 32'h30);

        // Stall holds E and suppresses the cc write
        drive(3'd1, 4'h6, 4'h0, 32'd1, 32'd1, 32'h0, 4'h5, 4'hF);
        tick();
        e_stall = 1'b1;
        drive(3'd1, 4'h3, 4'h0, 32'h0, 32'h0, 32'd77, 4'h6, 4'h6);
        tick();
        check("stall_icode", {28'd0, bus.E_icode}, 32'h6);
        check("stall_valE",  bus.e_valE,           32'd2);
        check("stall_dstE",  {28'd0, bus.e_dstE},  32'h5);
        check("stall_cc",    {29'd0, bus.cc},      32'h1);

        // Bubble wins over stall
        e_bubble = 1'b1;
        tick();
        check("bub_icode", {28'd0, bus.E_icode}, 32'h1);
        check("bub_dstM",  {28'd0, bus.E_dstM},  32'hF);
        check("bub_dstE",  {28'd0, bus.e_dstE},  32'hF);
        check("bub_cc",    {29'd0, bus.cc},      32'h1);

        // OPq bubbled out before its E cycle leaves cc alone
        e_stall = 1'b0;
        drive(3'd1, 4'h6, 4'h1, 32'd5, 32'd5, 32'h0, 4'h4, 4'hF);
        tick();
        check("bubop_icode", {28'd0, bus.E_icode}, 32'h1);
        tick();
        check("bubop_cc",    {29'd0, bus.cc},      32'h1);

        // Exception gating on the cc write
        e_bubble = 1'b0;
        drive(3'd1, 4'h6, 4'h3, 32'd3, 32'd3, 32'h0, 4'h2, 4'hF);
        tick();
        check("xor33_valE", bus.e_valE, 32'h0);
        m_exc = 1'b1;
        drive(3'd2, 4'h1, 4'h0, 32'h0, 32'h0, 32'h0, 4'hF, 4'hF);
        tick();
`ifdef EXE_EXC_CC_GATE_EN
        check("exc_cc", {29'd0, bus.cc}, 32'h1);
`else
        check("exc_cc", {29'd0, bus.cc}, 32'h4);
`endif
        check("hlt_stat", {29'd0, bus.E_stat}, 32'h2);
        m_exc = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
